// File: rtl/nanorv32_tcm_loader_arb_pkg.sv
// Shared definitions for the code-TCM loader/arbiter: FSM encodings and data-path widths.
package nanorv32_tcm_loader_arb_pkg;

  typedef enum logic [1:0] {
    LDARB_RUN   = 2'd0,
    LDARB_LOAD  = 2'd1,
    LDARB_WRITE = 2'd2,
    LDARB_HOLD  = 2'd3
  } ldarb_state_e;

  localparam int NANORV32_DATA_MSB = 31;
  localparam int HOLD_CNT_W        = 4;

endpackage

// File: rtl/nanorv32_tcm_loader_arb_byte_packer.sv
// Packs loader bytes little-endian into 32-bit words; a short final word comes out zero-filled.
module nanorv32_tcm_loader_arb_byte_packer
  import nanorv32_tcm_loader_arb_pkg::*;
(
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       clr,
  input  logic                       accept,
  input  logic [7:0]                 byte_in,
  input  logic                       last,
  output logic                       word_rdy,
  output logic [NANORV32_DATA_MSB:0] word
);

  logic [1:0]                 idx;
  logic [NANORV32_DATA_MSB:0] acc;
  logic [NANORV32_DATA_MSB:0] merged;

  // acc is cleared at each word start, so unfilled upper lanes are already zero
  always_comb begin
    merged = acc;
    merged[{idx, 3'b000} +: 8] = byte_in;
  end

  assign word_rdy = accept & ((idx == 2'd3) | last);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      idx  <= 2'd0;
      acc  <= '0;
      word <= '0;
    end else if (clr) begin
      idx <= 2'd0;
      acc <= '0;
    end else if (accept) begin
      if (word_rdy) begin
        word <= merged;
        acc  <= '0;
        idx  <= 2'd0;
      end else begin
        acc <= merged;
        idx <= idx + 2'd1;
      end
    end
  end

endmodule

// File: rtl/nanorv32_tcm_loader_arb.sv
// Code-TCM owner shared between the CPU bus and a byte-stream program loader.
// Optional running checksum of written words: define NANORV32_LOADER_CHECKSUM_EN.
//
// state       | meaning
// LDARB_RUN   | CPU out of reset, owns the TCM
// LDARB_LOAD  | CPU held, accepting loader bytes
// LDARB_WRITE | one-cycle write of the packed word at ptr
// LDARB_HOLD  | image done, CPU reset held RST_HOLD cycles
module nanorv32_tcm_loader_arb
  import nanorv32_tcm_loader_arb_pkg::*;
#(
  parameter int ADDR_W    = 16,
  parameter int MEM_WORDS = 1 << (ADDR_W - 2),
  parameter bit BOOT_LOAD = 1'b1,
  parameter int RST_HOLD  = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              ld_start,
  input  logic              ld_valid,
  input  logic [7:0]        ld_data,
  input  logic              ld_last,
  output logic              ld_ready,
  output logic              ld_done,
  output logic              ld_ovf,
  output logic [31:0]       ld_csum,
  output logic              cpu_rst_n,
  input  logic              cpu_req,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [3:0]        cpu_we,
  input  logic [31:0]       cpu_wdata,
  output logic              cpu_gnt,
  output logic [31:0]       cpu_rdata,
  output logic              mem_en,
  output logic [3:0]        mem_we,
  output logic [ADDR_W-3:0] mem_addr,
  output logic [31:0]       mem_wdata,
  input  logic [31:0]       mem_rdata
);

  // one extra pointer bit so ptr can sit at MEM_WORDS once the TCM is full
  localparam int                PTR_W   = ADDR_W - 1;
  localparam logic [PTR_W-1:0]  PTR_MAX = PTR_W'(MEM_WORDS);

  ldarb_state_e          state_q, state_d;
  logic [PTR_W-1:0]      ptr_q;
  logic [HOLD_CNT_W-1:0] hold_q;
  logic                  last_q, done_q, ovf_q;
  logic                  accept, word_rdy, wr_ovf, wr_commit;
  logic [31:0]           word;
  logic                  unused_addr_lsb;

  assign unused_addr_lsb = &{1'b0, cpu_addr[1:0]};

  assign accept    = (state_q == LDARB_LOAD) & ld_valid & ~ld_start;
  assign wr_ovf    = (ptr_q == PTR_MAX);
  assign wr_commit = (state_q == LDARB_WRITE) & ~wr_ovf;

  nanorv32_tcm_loader_arb_byte_packer u_packer (
    .clk      (clk),
    .rst_n    (rst_n),
    .clr      (ld_start),
    .accept   (accept),
    .byte_in  (ld_data),
    .last     (ld_last),
    .word_rdy (word_rdy),
    .word     (word)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= BOOT_LOAD ? LDARB_LOAD : LDARB_RUN;
      ptr_q   <= '0;
      hold_q  <= '0;
      last_q  <= 1'b0;
      done_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      if (word_rdy) last_q <= ld_last;
      if (state_q == LDARB_WRITE) hold_q <= HOLD_CNT_W'(RST_HOLD - 1);
      else if (state_q == LDARB_HOLD) hold_q <= hold_q - 1'b1;
      if (ld_start) begin
        ptr_q  <= '0;
        done_q <= 1'b0;
        ovf_q  <= 1'b0;
      end else begin
        if (wr_commit) ptr_q <= ptr_q + PTR_W'(1);
        if ((state_q == LDARB_WRITE) && wr_ovf) ovf_q <= 1'b1;
        if ((state_q == LDARB_HOLD) && (state_d == LDARB_RUN)) done_q <= 1'b1;
      end
    end
  end

  always_comb begin
    state_d   = state_q;
    ld_ready  = 1'b0;
    cpu_rst_n = 1'b0;
    cpu_gnt   = 1'b0;
    mem_en    = 1'b0;
    mem_we    = 4'h0;
    mem_addr  = ptr_q[ADDR_W-3:0];
    mem_wdata = word;
    case (state_q)
      LDARB_RUN: begin
        cpu_rst_n = 1'b1;
        cpu_gnt   = cpu_req;
        mem_en    = cpu_req;
        mem_we    = cpu_req ? cpu_we : 4'h0;
        mem_addr  = cpu_addr[ADDR_W-1:2];
        mem_wdata = cpu_wdata;
      end
      LDARB_LOAD: begin
        ld_ready = ~ld_start;
        if (word_rdy) state_d = LDARB_WRITE;
      end
      LDARB_WRITE: begin
        mem_en  = ~wr_ovf;
        mem_we  = 4'hF;
        state_d = last_q ? LDARB_HOLD : LDARB_LOAD;
      end
      LDARB_HOLD: begin
        if (hold_q == '0) state_d = LDARB_RUN;
      end
      default: state_d = LDARB_LOAD;
    endcase
    if (ld_start) state_d = LDARB_LOAD;
    // no TCM access or grant while the block itself is being reset
    if (!rst_n) begin
      cpu_gnt = 1'b0;
      mem_en  = 1'b0;
      mem_we  = 4'h0;
    end
  end

  assign cpu_rdata = mem_rdata;
  assign ld_done   = done_q;
  assign ld_ovf    = ovf_q;

`ifdef NANORV32_LOADER_CHECKSUM_EN
  logic [31:0] csum_q;
  always_ff @(posedge clk) begin
    if (!rst_n)         csum_q <= '0;
    else if (ld_start)  csum_q <= '0;
    else if (wr_commit) csum_q <= csum_q + word;
  end
  assign ld_csum = csum_q;
`else
  assign ld_csum = 32'h0;
`endif

endmodule
